// File: rtl/core_hazard_ctrl.sv
// core_hazard_ctrl: pipeline sequencing controller for the i2d core.
// Generates IF/ID hold, EX bubble and ID flush from load-use hazards,
// taken branches and MAU back-pressure.
// Optional feature macro: CORE_CTRL_PERF_EN enables the stall/flush
// performance counters; without it both counter ports read as zero.
module core_hazard_ctrl #(
    parameter int LOAD_STALL  = 1,  // total stall cycles per load-use hazard (1..3)
    parameter int FLUSH_DEPTH = 2   // total flush cycles per taken branch (1..3)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rega_addr,
    input  logic [3:0]  id_regb_addr,
    input  logic        id_use_a,
    input  logic        id_use_b,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic [3:0]  ex_dst_addr,
    input  logic        ex_branch_taken,
    input  logic        mau_busy,
    output logic        if_halt,
    output logic        id_halt,
    output logic        ex_bubble,
    output logic        flush,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MAUWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    // Remaining extra cycles loaded on entry; the entry cycle itself is
    // spent in RUN, so a stall/flush of N cycles loads N-2.
    localparam logic [1:0] LS_INIT = 2'((LOAD_STALL  > 1) ? (LOAD_STALL  - 2) : 0);
    localparam logic [1:0] FL_INIT = 2'((FLUSH_DEPTH > 1) ? (FLUSH_DEPTH - 2) : 0);

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       haz;

    // Load-use hazard: EX load writes a register the ID instruction reads.
    assign haz = ex_valid & ex_load &
                 ((id_use_a & (id_rega_addr == ex_dst_addr)) |
                  (id_use_b & (id_regb_addr == ex_dst_addr)));

    // State and shared down-counter register.
    // NOTE: sequential state uses non-blocking (<=) so all flops update
    // together at the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and combinational control outputs.
    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned (that would infer a latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if_halt   = 1'b0;
        id_halt   = 1'b0;
        ex_bubble = 1'b0;
        flush     = 1'b0;
        case (state)
            RUN: begin
                if (mau_busy) begin
                    if_halt   = 1'b1;
                    id_halt   = 1'b1;
                    state_nxt = MAUWAIT;
                end else if (ex_branch_taken) begin
                    // Branch wins over a simultaneous hazard: the hazard
                    // instruction is in the shadow and gets squashed.
                    flush = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = FL_INIT;
                    end
                end else if (haz) begin
                    if_halt   = 1'b1;
                    id_halt   = 1'b1;
                    ex_bubble = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_nxt = LDSTALL;
                        cnt_nxt   = LS_INIT;
                    end
                end
            end
            LDSTALL: begin
                if_halt   = 1'b1;
                id_halt   = 1'b1;
                ex_bubble = 1'b1;
                if (mau_busy) begin
                    // MAU stall supersedes whatever load stall remains.
                    state_nxt = MAUWAIT;
                end else if (cnt == 2'd0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            MAUWAIT: begin
                // EX must keep its instruction, so no bubble here.
                if_halt = 1'b1;
                id_halt = 1'b1;
                if (!mau_busy) begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                // IF runs free to fetch from the branch target; a held
                // branch in EX is a squashed copy and is ignored.
                flush = 1'b1;
                if (mau_busy) begin
                    if_halt = 1'b1;
                    id_halt = 1'b1;
                end else if (cnt == 2'd0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    assign ctrl_state = state;

`ifdef CORE_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q;

    // Saturating performance counters for halt and flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (id_halt && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed testbench for core_hazard_ctrl. Two instances share stimulus:
// dut_a uses LOAD_STALL=1/FLUSH_DEPTH=2, dut_b uses LOAD_STALL=3/FLUSH_DEPTH=1.
// Controls are compared as the nibble {if_halt, id_halt, ex_bubble, flush}.
module tb_core_hazard_ctrl;

`ifdef CORE_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  id_rega_addr, id_regb_addr, ex_dst_addr;
    logic        id_use_a, id_use_b, ex_valid, ex_load, ex_branch_taken, mau_busy;

    logic        if_halt_a, id_halt_a, ex_bubble_a, flush_a;
    logic        if_halt_b, id_halt_b, ex_bubble_b, flush_b;
    logic [1:0]  state_a, state_b;
    logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    core_hazard_ctrl #(.LOAD_STALL(1), .FLUSH_DEPTH(2)) dut_a (
        .clk(clk), .rst(rst),
        .id_rega_addr(id_rega_addr), .id_regb_addr(id_regb_addr),
        .id_use_a(id_use_a), .id_use_b(id_use_b),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_dst_addr(ex_dst_addr),
        .ex_branch_taken(ex_branch_taken), .mau_busy(mau_busy),
        .if_halt(if_halt_a), .id_halt(id_halt_a), .ex_bubble(ex_bubble_a),
        .flush(flush_a), .ctrl_state(state_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    core_hazard_ctrl #(.LOAD_STALL(3), .FLUSH_DEPTH(1)) dut_b (
        .clk(clk), .rst(rst),
        .id_rega_addr(id_rega_addr), .id_regb_addr(id_regb_addr),
        .id_use_a(id_use_a), .id_use_b(id_use_b),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_dst_addr(ex_dst_addr),
        .ex_branch_taken(ex_branch_taken), .mau_busy(mau_busy),
        .if_halt(if_halt_b), .id_halt(id_halt_b), .ex_bubble(ex_bubble_b),
        .flush(flush_b), .ctrl_state(state_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    wire [3:0] ctl_a = {if_halt_a, id_halt_a, ex_bubble_a, flush_a};
    wire [3:0] ctl_b = {if_halt_b, id_halt_b, ex_bubble_b, flush_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_rega_addr    = 4'h0;
        id_regb_addr    = 4'h0;
        ex_dst_addr     = 4'h0;
        id_use_a        = 1'b0;
        id_use_b        = 1'b0;
        ex_valid        = 1'b0;
        ex_load         = 1'b0;
        ex_branch_taken = 1'b0;
        mau_busy        = 1'b0;
    endtask

    // Load in EX writing r3, ID reading r3 on operand A.
    task automatic drive_haz;
        ex_valid     = 1'b1;
        ex_load      = 1'b1;
        ex_dst_addr  = 4'h3;
        id_rega_addr = 4'h3;
        id_use_a     = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        check("reset ctl_a", 32'(ctl_a), 32'h0);
        check("reset ctl_b", 32'(ctl_b), 32'h0);
        check("reset state_a", 32'(state_a), 32'd0);
        check("reset stall_cnt_a", stall_cnt_a, 32'd0);
        check("reset flush_cnt_b", flush_cnt_b, 32'd0);
        tick();
        rst = 1'b0;

        // ---- load-use hazard: one cycle of stimulus ----
        tick(); drive_haz(); #1;
        check("haz0 ctl_a", 32'(ctl_a), 32'hE);
        check("haz0 state_a", 32'(state_a), 32'd0);
        check("haz0 ctl_b", 32'(ctl_b), 32'hE);
        check("haz0 state_b", 32'(state_b), 32'd0);
        tick(); clear_inputs(); #1;
        check("haz1 ctl_a", 32'(ctl_a), 32'h0);
        check("haz1 ctl_b", 32'(ctl_b), 32'hE);
        check("haz1 state_b", 32'(state_b), 32'd1);
        tick(); #1;
        check("haz2 ctl_b", 32'(ctl_b), 32'hE);
        check("haz2 state_b", 32'(state_b), 32'd1);
        tick(); #1;
        check("haz3 ctl_b", 32'(ctl_b), 32'h0);
        check("haz3 state_b", 32'(state_b), 32'd0);

        // ---- taken branch ----
        tick(); ex_branch_taken = 1'b1; #1;
        check("br0 ctl_a", 32'(ctl_a), 32'h1);
        check("br0 ctl_b", 32'(ctl_b), 32'h1);
        tick(); clear_inputs(); #1;
        check("br1 ctl_a", 32'(ctl_a), 32'h1);
        check("br1 state_a", 32'(state_a), 32'd3);
        check("br1 ctl_b", 32'(ctl_b), 32'h0);
        tick(); #1;
        check("br2 ctl_a", 32'(ctl_a), 32'h0);
        check("br2 state_a", 32'(state_a), 32'd0);
        check("perf stall_cnt_a", stall_cnt_a, 32'(1 * PERF));
        check("perf stall_cnt_b", stall_cnt_b, 32'(3 * PERF));
        check("perf flush_cnt_a", flush_cnt_a, 32'(2 * PERF));
        check("perf flush_cnt_b", flush_cnt_b, 32'(1 * PERF));

        // ---- hazard qualifiers (dut_a; idle long enough for dut_b) ----
        tick(); drive_haz(); ex_valid = 1'b0; #1;
        check("noval ctl_a", 32'(ctl_a), 32'h0);
        tick(); drive_haz(); ex_load = 1'b0; #1;
        check("noload ctl_a", 32'(ctl_a), 32'h0);
        tick(); drive_haz(); id_use_a = 1'b0; id_regb_addr = 4'h3; #1;
        check("nouse ctl_a", 32'(ctl_a), 32'h0);
        tick(); drive_haz(); id_rega_addr = 4'h5; id_regb_addr = 4'h3; id_use_b = 1'b1; #1;
        check("opb ctl_a", 32'(ctl_a), 32'hE);
        tick(); clear_inputs();
        for (int i = 0; i < 3; i++) tick();
        drive_haz(); ex_dst_addr = 4'h0; id_rega_addr = 4'h0; #1;
        check("r0 ctl_a", 32'(ctl_a), 32'hE);
        tick(); clear_inputs();
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("idle state_b", 32'(state_b), 32'd0);

        // ---- branch and hazard together: branch wins ----
        drive_haz(); ex_branch_taken = 1'b1; #1;
        check("brhaz0 ctl_a", 32'(ctl_a), 32'h1);
        check("brhaz0 ctl_b", 32'(ctl_b), 32'h1);
        tick(); clear_inputs(); #1;
        check("brhaz1 ctl_a", 32'(ctl_a), 32'h1);
        check("brhaz1 ctl_b", 32'(ctl_b), 32'h0);
        check("brhaz1 state_b", 32'(state_b), 32'd0);
        tick(); #1;
        check("brhaz2 ctl_a", 32'(ctl_a), 32'h0);

        // ---- MAU busy 4 cycles with a branch held in EX ----
        ex_branch_taken = 1'b1;
        mau_busy        = 1'b1;
        #1;
        check("mau0 ctl_a", 32'(ctl_a), 32'hC);
        check("mau0 state_a", 32'(state_a), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            check("mau ctl_a", 32'(ctl_a), 32'hC);
            check("mau state_a", 32'(state_a), 32'd2);
        end
        tick(); mau_busy = 1'b0; #1;
        check("maurel ctl_a", 32'(ctl_a), 32'hC);
        check("maurel state_a", 32'(state_a), 32'd2);
        tick(); #1;
        check("maurun ctl_a", 32'(ctl_a), 32'h1);
        check("maurun state_a", 32'(state_a), 32'd0);
        check("maurun ctl_b", 32'(ctl_b), 32'h1);
        tick(); clear_inputs(); #1;
        check("maufl ctl_a", 32'(ctl_a), 32'h1);
        check("maufl ctl_b", 32'(ctl_b), 32'h0);
        tick(); #1;
        check("maudone ctl_a", 32'(ctl_a), 32'h0);

        // ---- MAU busy 2 cycles inside FLUSH (dut_a) ----
        ex_branch_taken = 1'b1; #1;
        check("fm0 ctl_a", 32'(ctl_a), 32'h1);
        tick(); ex_branch_taken = 1'b0; mau_busy = 1'b1; #1;
        check("fm1 ctl_a", 32'(ctl_a), 32'hD);
        check("fm1 state_a", 32'(state_a), 32'd3);
        check("fm1 ctl_b", 32'(ctl_b), 32'hC);
        tick(); #1;
        check("fm2 ctl_a", 32'(ctl_a), 32'hD);
        check("fm2 state_b", 32'(state_b), 32'd2);
        tick(); mau_busy = 1'b0; #1;
        check("fm3 ctl_a", 32'(ctl_a), 32'h1);
        check("fm3 state_a", 32'(state_a), 32'd3);
        tick(); #1;
        check("fm4 ctl_a", 32'(ctl_a), 32'h0);
        check("fm4 state_a", 32'(state_a), 32'd0);
        check("fm4 state_b", 32'(state_b), 32'd0);

        // ---- asynchronous reset in the middle of LDSTALL (dut_b) ----
        tick(); drive_haz(); #1;
        tick(); clear_inputs(); #1;
        check("prerst state_b", 32'(state_b), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst ctl_b", 32'(ctl_b), 32'h0);
        check("arst state_b", 32'(state_b), 32'd0);
        check("arst stall_cnt_b", stall_cnt_b, 32'd0);
        check("arst flush_cnt_a", flush_cnt_a, 32'd0);
        tick(); rst = 1'b0; #1;
        check("postrst ctl_b", 32'(ctl_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
